reg_bank_dump_ctrl: RTL and testbench
=====================================

# reg_bank_dump_ctrl

Debug readout controller sitting directly downstream of the parameterised register bank. It consumes the bank's flattened `q` bus and streams every register word out, lowest address first, over a valid/ready handshake. The intended consumer is a UART/debug port. A single `start` pulse triggers one complete dump of all `REGS_QTY` registers, with a `done` pulse at the end.

## Interface
Parameters:
- `DATA_LENGTH`, 32, width of one register word.
- `REGS_QTY`, 32, number of registers in the bank.
- `ADDR_LENGTH`, `$clog2(REGS_QTY)`, localparam, width of `out_addr`.

Ports:
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `q_bank`  in  `DATA_LENGTH*REGS_QTY`  flattened register bank output; word i occupies bits `[(i+1)*DATA_LENGTH-1 : i*DATA_LENGTH]`.
- `start`  in  1  request one dump; sampled only in IDLE.
- `out_ready`  in  1  consumer accepts the current word.
- `out_valid`  out  1  `out_data`/`out_addr` hold a word to transfer.
- `out_data`  out  `DATA_LENGTH`  register word being offered.
- `out_addr`  out  `ADDR_LENGTH`  register index of `out_data`.
- `busy`  out  1  dump in progress (SEND state).
- `done`  out  1  one-cycle pulse after the last word is accepted.

## Operation
- FSM has three states: IDLE, SEND and DONE. Reset state is IDLE.
- IDLE, `start`=1:
  - load word 0 into `out_data` and 0 into `out_addr`;
  - set `out_valid`=1 and `busy`=1;
  - go to SEND.
- SEND, transfer (`out_valid && out_ready`), `out_addr` < `REGS_QTY-1`:
  - load word `out_addr+1` and increment `out_addr`;
  - `out_valid` stays 1, so there is no bubble.
- SEND, transfer, `out_addr` == `REGS_QTY-1`:
  - clear `out_valid` and `busy`;
  - set `done`=1;
  - go to DONE.
- SEND, no transfer: `out_data` and `out_addr` hold, and `out_valid` stays 1. Outputs are stable under backpressure.
- DONE: clear `done` and go to IDLE unconditionally.
- `start` is ignored in SEND and DONE. It is not queued.
- `out_addr` never wraps. The dump terminates at `REGS_QTY-1`.
- All outputs are registered, with no combinational path from inputs to outputs.
- Reset values: `out_valid`=0, `out_data`=0, `out_addr`=0, `busy`=0, `done`=0, state IDLE.
- Reset asserted mid-dump: everything returns to reset values immediately (asynchronous). No `done` is issued, and the dump is not resumed.

## Timing
- `start` sampled high at edge N: at N+1, `out_valid`=1 with word 0.
- With `out_ready` held high, word i is presented during cycles N+1+i.
- The last handshake is at edge N+`REGS_QTY`. `done`=1 for the cycle that follows it, with `busy`=0 and `out_valid`=0.
- Earliest next accepted `start` is at edge N+`REGS_QTY`+2 (back in IDLE).
- Throughput is one word per cycle, and total latency is `REGS_QTY`+1 cycles from `start` to `done` with no backpressure.
- Each stall cycle (`out_ready`=0 while `out_valid`=1) adds exactly one cycle.

## Configuration
- Macro: `DUMP_SNAPSHOT_EN`.
- Defined:
  - the whole `q_bank` is captured into an internal buffer at the `start` edge;
  - all words come from that buffer, giving an atomic snapshot;
  - bank writes during the dump are not reflected.
- Undefined:
  - no buffer;
  - word i is sampled live from `q_bank` at the edge that loads it (the `start` edge for word 0, otherwise the handshake edge of word i-1);
  - bank writes before that edge are visible.

## Test plan
- Reset check: assert `rst` mid-dump at word 5 -> all outputs 0 immediately, state IDLE, no `done`. After release, `start` begins again from `out_addr`=0.
- Bank at reset values, `out_ready`=1, pulse `start`:
  - 32 consecutive beats;
  - beat 2 = 0x7FFFEFFC, beat 3 = 0x10008000, all others 0;
  - `done` one cycle after beat 31, total 33 cycles.
- Backpressure: toggle `out_ready` 1,0,0,1,... -> each word held stable while stalled, every address 0..31 appears exactly once, in order.
- `start` held high through the whole dump and the DONE cycle -> exactly one dump; a new dump begins only when `start` is sampled in IDLE.
- Write reg 10 = 0xDEADBEEF during beat 4:
  - with `DUMP_SNAPSHOT_EN` -> beat 10 shows the old value 0;
  - without it -> beat 10 shows 0xDEADBEEF.

Source files
------------

// File: rtl/reg_bank_dump_ctrl.sv
// reg_bank_dump_ctrl: streams every register-bank word out, lowest address first, over valid/ready.
// Optional DUMP_SNAPSHOT_EN captures the whole bank at start so the dump is an atomic snapshot.
module reg_bank_dump_ctrl #(
   parameter int DATA_LENGTH = 32,
   parameter int REGS_QTY = 32,
   localparam int ADDR_LENGTH = $clog2(REGS_QTY)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [DATA_LENGTH*REGS_QTY-1:0] q_bank,
   input  logic                            start,
   input  logic                            out_ready,
   output logic                            out_valid,
   output logic [DATA_LENGTH-1:0]          out_data,
   output logic [ADDR_LENGTH-1:0]          out_addr,
   output logic                            busy,
   output logic                            done
);
   typedef enum logic [1:0] {IDLE, SEND, DONE} state_e;
   state_e state_q;
   logic out_valid_q, busy_q, done_q;
   logic [DATA_LENGTH-1:0] out_data_q;
   logic [ADDR_LENGTH-1:0] out_addr_q, addr_d;
   logic [DATA_LENGTH*REGS_QTY-1:0] src;
   logic [DATA_LENGTH-1:0] words [REGS_QTY];
`ifdef DUMP_SNAPSHOT_EN
   logic [DATA_LENGTH*REGS_QTY-1:0] snap_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) snap_q <= '0;
      else if (state_q == IDLE && start) snap_q <= q_bank;
   assign src = snap_q;
`else
   assign src = q_bank;
`endif
   for (genvar i = 0; i < REGS_QTY; i++) begin : g_w
      assign words[i] = src[i*DATA_LENGTH +: DATA_LENGTH];
   end
   assign addr_d = out_addr_q + 1'b1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state_q     <= IDLE;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_addr_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               state_q     <= SEND;
               out_data_q  <= q_bank[DATA_LENGTH-1:0];
               out_addr_q  <= '0;
               out_valid_q <= 1'b1;
               busy_q      <= 1'b1;
            end
            SEND: if (out_valid_q && out_ready) begin
               if (out_addr_q == ADDR_LENGTH'(REGS_QTY-1)) begin
                  state_q     <= DONE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  done_q      <= 1'b1;
               end else begin
                  out_data_q <= words[addr_d];
                  out_addr_q <= addr_d;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_addr  = out_addr_q;
   assign busy      = busy_q;
   assign done      = done_q;
endmodule

// File: tb/tb_reg_bank_dump_ctrl.sv
// tb_reg_bank_dump_ctrl: directed checks of dump order, backpressure, start handling, reset and bank writes.
module tb_reg_bank_dump_ctrl;
   localparam int DW = 32, RQ = 32;
   logic clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b0;
   logic [DW*RQ-1:0] q_bank;
   logic out_valid, busy, done;
   logic [DW-1:0] out_data;
   logic [4:0] out_addr;
   logic [DW-1:0] exp_w [RQ];
   int checks = 0, failures = 0;
   always #5 clk = ~clk;
   reg_bank_dump_ctrl #(.DATA_LENGTH(DW), .REGS_QTY(RQ)) dut (
      .clk(clk), .rst(rst), .q_bank(q_bank), .start(start), .out_ready(out_ready),
      .out_valid(out_valid), .out_data(out_data), .out_addr(out_addr), .busy(busy), .done(done)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic set_word(input int i, input logic [DW-1:0] v);
      q_bank[i*DW +: DW] = v;
   endtask
   task automatic dump(input bit stall, input bit hold, input bit wr10, input int abort_at, input int exp_len);
      int idx = 0, n = 0;
      bit fin = 1'b0, rdy;
      start = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      if (!hold) start = 1'b0;
      while (!fin && n < 200) begin
         n++;
         if (idx == abort_at) begin
            #2 rst = 1'b1;
            #1;
            check("rst_valid", out_valid, 0);
            check("rst_data", out_data, 0);
            check("rst_addr", out_addr, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            fin = 1'b1;
         end else if (idx < RQ) begin
            check($sformatf("valid%0d", idx), out_valid, 1);
            check($sformatf("addr%0d", idx), out_addr, idx);
            check($sformatf("data%0d", idx), out_data, exp_w[idx]);
            check($sformatf("busy%0d", idx), busy, 1);
            check($sformatf("done%0d", idx), done, 0);
            if (wr10 && idx == 4) begin
               set_word(10, 32'hDEADBEEF);
`ifndef DUMP_SNAPSHOT_EN
               exp_w[10] = 32'hDEADBEEF;
`endif
            end
            rdy = stall ? (n % 3 == 1) : 1'b1;
            out_ready = rdy;
            if (rdy) idx++;
            @(negedge clk);
         end else begin
            check("done_pulse", done, 1);
            check("done_valid", out_valid, 0);
            check("done_busy", busy, 0);
            check("latency", n, exp_len);
            fin = 1'b1;
         end
      end
      if (!fin) check("timeout", 0, 1);
      if (abort_at < 0) begin
         @(negedge clk);
         check("done_clr", done, 0);
         check("idle_valid", out_valid, 0);
      end
   endtask
   initial begin
      int k;
      q_bank = '0;
      set_word(2, 32'h7FFFEFFC);
      set_word(3, 32'h10008000);
      for (int i = 0; i < RQ; i++) exp_w[i] = q_bank[i*DW +: DW];
      repeat (2) @(negedge clk);
      check("reset_valid", out_valid, 0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      check("reset_addr", out_addr, 0);
      check("reset_data", out_data, 0);
      rst = 1'b0;
      @(negedge clk);
      dump(1'b0, 1'b0, 1'b0, 5, 0);
      repeat (2) @(negedge clk);
      check("inrst_valid", out_valid, 0);
      check("inrst_done", done, 0);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check("no_resume_valid", out_valid, 0);
      check("no_resume_done", done, 0);
      dump(1'b0, 1'b0, 1'b0, -1, 33);
      dump(1'b1, 1'b0, 1'b0, -1, 95);
      dump(1'b0, 1'b1, 1'b0, -1, 33);
      @(negedge clk);
      check("restart_valid", out_valid, 1);
      check("restart_addr", out_addr, 0);
      start = 1'b0;
      out_ready = 1'b1;
      k = 0;
      while (!done && k < 100) begin
         @(negedge clk);
         k++;
      end
      check("drain_done", done, 1);
      @(negedge clk);
      dump(1'b0, 1'b0, 1'b1, -1, 33);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
